riscv_core: RTL and testbench



---
 rtl/riscv_core.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_riscv_core.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core (with riscv_instr_mem, riscv_regfile, riscv_data_mem)
// Desc     : Single-cycle RV32I-subset processor. One instruction is fetched,
//            decoded, executed and retired on every rising clock edge.
// Revision : 1.0 - initial release
// ============================================================================

// Instruction store: combinational word read, plus a back-door write port
// that the core ties off (programs are placed by hierarchical access).
module riscv_instr_mem #(
  parameter int IMEM_WORDS = 256,
  parameter int AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:IMEM_WORDS-1];

  // Optional program-load write; unused inside the core
  always_ff @(posedge clk) begin
    if (we) memory[waddr] <= wdata;
  end

  assign rdata = memory[raddr];
endmodule

// 32x32 register file: two combinational reads, one synchronous write.
// A read of the register being written this cycle sees the old value.
module riscv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];

  // Clear everything on reset; x0 is never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (rd != 5'd0)) begin
      regs[rd] <= wd;
    end
  end

  assign rd1 = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rd2 = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
endmodule

// Data store: combinational word read, synchronous word write.
module riscv_data_mem #(
  parameter int DMEM_WORDS = 256,
  parameter int AW         = $clog2(DMEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:DMEM_WORDS-1];

  // Store word on the rising edge
  always_ff @(posedge clk) begin
    if (we) memory[idx] <= wdata;
  end

  assign rdata = memory[idx];
endmodule

module riscv_core #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int c_IAW = $clog2(IMEM_WORDS);
  localparam int c_DAW = $clog2(DMEM_WORDS);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;

  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_SLL  = 4'd2;
  localparam logic [3:0] c_ALU_SLT  = 4'd3;
  localparam logic [3:0] c_ALU_SLTU = 4'd4;
  localparam logic [3:0] c_ALU_XOR  = 4'd5;
  localparam logic [3:0] c_ALU_SRL  = 4'd6;
  localparam logic [3:0] c_ALU_SRA  = 4'd7;
  localparam logic [3:0] c_ALU_OR   = 4'd8;
  localparam logic [3:0] c_ALU_AND  = 4'd9;
  localparam logic [3:0] c_ALU_PASS = 4'd10;

  localparam logic [1:0] c_WB_ALU = 2'd0;
  localparam logic [1:0] c_WB_MEM = 2'd1;
  localparam logic [1:0] c_WB_PC4 = 2'd2;

  logic [31:0] PC;
  logic [31:0] Instr;
  logic        RegWrite;
  logic [31:0] ALUResult;

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_op2;
  logic [31:0] w_mem_rdata;
  logic [31:0] w_wb_data;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_target;
  logic [31:0] w_next_pc;
  logic [3:0]  w_alu_op;
  logic [1:0]  w_wb_sel;
  logic        w_use_imm;
  logic        w_mem_write;
  logic        w_redirect;

  // Field extraction and immediate formats
  assign w_opcode = Instr[6:0];
  assign w_rd     = Instr[11:7];
  assign w_funct3 = Instr[14:12];
  assign w_rs1    = Instr[19:15];
  assign w_rs2    = Instr[24:20];
  assign w_imm_i  = {{20{Instr[31]}}, Instr[31:20]};
  assign w_imm_s  = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
  assign w_imm_b  = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
  assign w_imm_j  = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
  assign w_imm_u  = {Instr[31:12], 12'd0};

  riscv_instr_mem #(.IMEM_WORDS(IMEM_WORDS)) instr_mem (
    .clk   (clk),
    .we    (1'b0),
    .waddr ('0),
    .wdata ('0),
    .raddr (PC[c_IAW+1:2]),
    .rdata (Instr)
  );

  riscv_regfile regfile (
    .clk (clk),
    .rst (rst),
    .rs1 (w_rs1),
    .rs2 (w_rs2),
    .rd  (w_rd),
    .we  (RegWrite),
    .wd  (w_wb_data),
    .rd1 (w_rs1_val),
    .rd2 (w_rs2_val)
  );

  // Stores are blocked while reset is held so an in-flight sw is dropped
  riscv_data_mem #(.DMEM_WORDS(DMEM_WORDS)) data_mem (
    .clk   (clk),
    .we    (w_mem_write & ~rst),
    .idx   (ALUResult[c_DAW+1:2]),
    .wdata (w_rs2_val),
    .rdata (w_mem_rdata)
  );

  // Control decode; anything unrecognised falls through as a NOP
  always_comb begin
    RegWrite    = 1'b0;
    w_mem_write = 1'b0;
    w_use_imm   = 1'b1;
    w_imm       = w_imm_i;
    w_alu_op    = c_ALU_ADD;
    w_wb_sel    = c_WB_ALU;
    w_redirect  = 1'b0;
    case (w_opcode)
      c_OP_R, c_OP_IMM: begin
        RegWrite  = 1'b1;
        w_use_imm = (w_opcode == c_OP_IMM);
        case (w_funct3)
          3'b000:  w_alu_op = (w_opcode == c_OP_R && Instr[30]) ? c_ALU_SUB : c_ALU_ADD;
          3'b001:  w_alu_op = c_ALU_SLL;
          3'b010:  w_alu_op = c_ALU_SLT;
          3'b011:  w_alu_op = c_ALU_SLTU;
          3'b100:  w_alu_op = c_ALU_XOR;
          3'b101:  w_alu_op = Instr[30] ? c_ALU_SRA : c_ALU_SRL;
          3'b110:  w_alu_op = c_ALU_OR;
          default: w_alu_op = c_ALU_AND;
        endcase
      end
      c_OP_LOAD: begin
        if (w_funct3 == 3'b010) begin
          RegWrite = 1'b1;
          w_wb_sel = c_WB_MEM;
        end
      end
      c_OP_STORE: begin
        w_imm = w_imm_s;
        if (w_funct3 == 3'b010) w_mem_write = 1'b1;
      end
      c_OP_BRANCH: begin
        w_imm     = w_imm_b;
        w_use_imm = 1'b0;
        w_alu_op  = c_ALU_SUB;
        if (w_funct3 == 3'b000) w_redirect = (w_rs1_val == w_rs2_val);
        else if (w_funct3 == 3'b001) w_redirect = (w_rs1_val != w_rs2_val);
      end
      c_OP_JAL: begin
        RegWrite   = 1'b1;
        w_imm      = w_imm_j;
        w_wb_sel   = c_WB_PC4;
        w_redirect = 1'b1;
      end
      c_OP_LUI: begin
        RegWrite = 1'b1;
        w_imm    = w_imm_u;
        w_alu_op = c_ALU_PASS;
      end
      default: ;
    endcase
  end

  assign w_op2 = w_use_imm ? w_imm : w_rs2_val;

  // ALU: rs1 op operand2 (operand2 alone for lui)
  always_comb begin
    ALUResult = 32'd0;
    case (w_alu_op)
      c_ALU_ADD:  ALUResult = w_rs1_val + w_op2;
      c_ALU_SUB:  ALUResult = w_rs1_val - w_op2;
      c_ALU_SLL:  ALUResult = w_rs1_val << w_op2[4:0];
      c_ALU_SLT:  ALUResult = {31'd0, ($signed(w_rs1_val) < $signed(w_op2))};
      c_ALU_SLTU: ALUResult = {31'd0, (w_rs1_val < w_op2)};
      c_ALU_XOR:  ALUResult = w_rs1_val ^ w_op2;
      c_ALU_SRL:  ALUResult = w_rs1_val >> w_op2[4:0];
      c_ALU_SRA:  ALUResult = $signed(w_rs1_val) >>> w_op2[4:0];
      c_ALU_OR:   ALUResult = w_rs1_val | w_op2;
      c_ALU_AND:  ALUResult = w_rs1_val & w_op2;
      c_ALU_PASS: ALUResult = w_op2;
      default:    ALUResult = 32'd0;
    endcase
  end

  assign w_pc_plus4  = PC + 32'd4;
  assign w_pc_target = PC + w_imm;
  assign w_next_pc   = w_redirect ? w_pc_target : w_pc_plus4;

  // Writeback source selection
  always_comb begin
    w_wb_data = ALUResult;
    case (w_wb_sel)
      c_WB_MEM: w_wb_data = w_mem_rdata;
      c_WB_PC4: w_wb_data = w_pc_plus4;
      default:  w_wb_data = ALUResult;
    endcase
  end

  // Program counter, forced to RESET_PC as soon as reset asserts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) PC <= RESET_PC;
    else     PC <= w_next_pc;
  end
endmodule
`default_nettype wire

// File: tb/tb_riscv_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core
// Desc     : Self-checking bench for riscv_core: directed programs plus random
//            programs compared against an instruction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_core;
  localparam int IMEM_WORDS = 256;
  localparam int DMEM_WORDS = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  riscv_core #(
    .IMEM_WORDS (IMEM_WORDS),
    .DMEM_WORDS (DMEM_WORDS),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Reference machine state
  logic [31:0] m_imem [IMEM_WORDS];
  logic [31:0] m_dmem [DMEM_WORDS];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;

  // Effects of the instruction at m_pc
  bit          e_we;
  bit          e_alu_ok;
  bit          e_mw;
  logic [4:0]  e_rd;
  logic [31:0] e_alu;
  logic [31:0] e_wd;
  logic [31:0] e_npc;
  logic [31:0] e_mdata;
  int          e_midx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    int sh;
    sh = 32 - bits;
    return 32'($signed(v << sh) >>> sh);
  endfunction

  // Instruction-level semantics of the supported subset
  task automatic model_peek();
    logic [31:0] ins, a, b, immi, imms, immb, immj;
    logic [4:0]  sh;
    ins  = m_imem[(m_pc >> 2) % IMEM_WORDS];
    a    = m_regs[ins[19:15]];
    b    = m_regs[ins[24:20]];
    immi = sext({20'd0, ins[31:20]}, 12);
    imms = sext({20'd0, ins[31:25], ins[11:7]}, 12);
    immb = sext({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
    immj = sext({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
    e_we = 0; e_alu_ok = 0; e_mw = 0; e_rd = ins[11:7];
    e_alu = 0; e_wd = 0; e_npc = m_pc + 4; e_mdata = b; e_midx = 0;
    if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) begin
      logic [31:0] y;
      bit          imm_form;
      imm_form = (ins[6:0] == 7'h13);
      if (imm_form) y = immi; else y = b;
      sh = y[4:0];
      e_we = 1; e_alu_ok = 1;
      case (ins[14:12])
        3'd0: e_alu = (!imm_form && ins[30]) ? a - y : a + y;
        3'd1: e_alu = a << sh;
        3'd2: e_alu = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
        3'd3: e_alu = (a < y) ? 32'd1 : 32'd0;
        3'd4: e_alu = a ^ y;
        3'd5: begin
          if (ins[30]) e_alu = $signed(a) >>> sh;
          else         e_alu = a >> sh;
        end
        3'd6: e_alu = a | y;
        default: e_alu = a & y;
      endcase
      e_wd = e_alu;
    end else if (ins[6:0] == 7'h03 && ins[14:12] == 3'd2) begin
      e_we = 1; e_alu_ok = 1; e_alu = a + immi;
      e_wd = m_dmem[(e_alu >> 2) % DMEM_WORDS];
    end else if (ins[6:0] == 7'h23 && ins[14:12] == 3'd2) begin
      e_mw = 1; e_alu_ok = 1; e_alu = a + imms;
      e_midx = int'((e_alu >> 2) % DMEM_WORDS);
    end else if (ins[6:0] == 7'h63) begin
      if ((ins[14:12] == 3'd0 && a == b) || (ins[14:12] == 3'd1 && a != b))
        e_npc = m_pc + immb;
    end else if (ins[6:0] == 7'h6f) begin
      e_we = 1; e_wd = m_pc + 4; e_npc = m_pc + immj;
    end else if (ins[6:0] == 7'h37) begin
      e_we = 1; e_alu_ok = 1; e_alu = {ins[31:12], 12'd0}; e_wd = e_alu;
    end
  endtask

  task automatic model_commit();
    if (e_we && e_rd != 0) m_regs[e_rd] = e_wd;
    if (e_mw) m_dmem[e_midx] = e_mdata;
    m_pc = e_npc;
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
  endtask

  // Hold reset for one cycle while placing the program; release at a falling edge
  task automatic load_program(input logic [31:0] prog [$], input bit rnd_data);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < IMEM_WORDS; i++) begin
      m_imem[i] = (i < prog.size()) ? prog[i] : 32'd0;
      dut.instr_mem.memory[i] = m_imem[i];
    end
    for (int i = 0; i < DMEM_WORDS; i++) begin
      m_dmem[i] = rnd_data ? $urandom : 32'd0;
      dut.data_mem.memory[i] = m_dmem[i];
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic run_cycles(input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      model_peek();
      check($sformatf("%s_pc[%0d]", tag, c), dut.PC, m_pc);
      check($sformatf("%s_instr[%0d]", tag, c), dut.Instr, m_imem[(m_pc >> 2) % IMEM_WORDS]);
      check($sformatf("%s_regwrite[%0d]", tag, c), {31'd0, dut.RegWrite}, {31'd0, e_we});
      if (e_alu_ok) check($sformatf("%s_alu[%0d]", tag, c), dut.ALUResult, e_alu);
      model_commit();
      @(negedge clk);
      #1;
      if (e_we && e_rd != 0)
        check($sformatf("%s_wb[%0d]", tag, c), dut.regfile.regs[e_rd], m_regs[e_rd]);
    end
  endtask

  task automatic compare_all(input string tag);
    for (int r = 0; r < 32; r++)
      check($sformatf("%s_x%0d", tag, r), dut.regfile.regs[r], m_regs[r]);
    for (int i = 0; i < DMEM_WORDS; i++)
      check($sformatf("%s_dmem[%0d]", tag, i), dut.data_mem.memory[i], m_dmem[i]);
  endtask

  // Encoders used to build random programs
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int off, input logic [4:0] rd);
    logic [20:0] im;
    im = off[20:0];
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2, sh;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] u;
    int          kind;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    sh  = 5'($urandom);
    f3  = 3'($urandom);
    imm = 12'($urandom);
    u   = $urandom;
    kind = $urandom_range(0, 11);
    case (kind)
      0, 1, 2: begin
        if (f3 == 3'd1) imm = {7'd0, sh};
        else if (f3 == 3'd5) imm = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, sh};
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      3, 4: begin
        logic [6:0] f7;
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return {f7, rs2, rs1, f3, rd, 7'h33};
      end
      5: return {u[31:12], rd, 7'h37};
      6: return enc_i(imm, rs1, 3'd2, rd, 7'h03);
      7: return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'h23};
      8: return enc_b(4 * $urandom_range(1, 4), rs2, rs1, 3'($urandom_range(0, 1)));
      9: return enc_j(($urandom_range(0, 7) == 0) ? -8 : 4 * $urandom_range(1, 4), rd);
      10: begin
        case ($urandom_range(0, 3))
          0: return 32'd0;
          1: return enc_i(imm, rs1, 3'd0, rd, 7'h03);
          2: return {u[31:12], rd, 7'h17};
          default: return enc_b(8, rs2, rs1, 3'd4);
        endcase
      end
      default: return enc_i(imm, rs1, 3'd0, rd, 7'h13);
    endcase
  endfunction

  initial begin
    logic [31:0] prog [$];
    logic [31:0] exp_alu [5];
    logic [31:0] exp_rw  [5];

    // Reset and straight-line program (loaded while reset is held from time 0)
    prog = '{32'h00500093, 32'h00300113, 32'h002081b3, 32'h00302023, 32'h00002203};
    for (int i = 0; i < IMEM_WORDS; i++)
      dut.instr_mem.memory[i] = (i < prog.size()) ? prog[i] : 32'd0;
    for (int i = 0; i < DMEM_WORDS; i++) dut.data_mem.memory[i] = 32'd0;
    #12;
    check("reset_pc", dut.PC, 32'h0);
    for (int r = 0; r < 32; r++) check($sformatf("reset_x%0d", r), dut.regfile.regs[r], 32'd0);
    #8;
    rst = 1'b0;
    #1;
    exp_alu = '{32'd5, 32'd3, 32'd8, 32'd0, 32'd0};
    exp_rw  = '{32'd1, 32'd1, 32'd1, 32'd0, 32'd1};
    for (int i = 0; i < 5; i++) begin
      check($sformatf("line_pc[%0d]", i), dut.PC, 32'(4 * i));
      check($sformatf("line_alu[%0d]", i), dut.ALUResult, exp_alu[i]);
      check($sformatf("line_regwrite[%0d]", i), {31'd0, dut.RegWrite}, exp_rw[i]);
      @(negedge clk);
      #1;
    end
    check("line_x1", dut.regfile.regs[1], 32'd5);
    check("line_x2", dut.regfile.regs[2], 32'd3);
    check("line_x3", dut.regfile.regs[3], 32'd8);
    check("line_x4", dut.regfile.regs[4], 32'd8);
    check("line_dmem0", dut.data_mem.memory[0], 32'd8);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("nop_pc[%0d]", k), dut.PC, 32'(20 + 4 * k));
      check($sformatf("nop_regwrite[%0d]", k), {31'd0, dut.RegWrite}, 32'd0);
      @(negedge clk);
      #1;
    end

    // x0 is never written even though the instruction requests it
    prog = '{32'h00700013};
    load_program(prog, 1'b0);
    check("x0_regwrite", {31'd0, dut.RegWrite}, 32'd1);
    check("x0_alu", dut.ALUResult, 32'd7);
    @(negedge clk);
    #1;
    check("x0_value", dut.regfile.regs[0], 32'd0);
    check("x0_pc", dut.PC, 32'h4);

    // beq x0,x0,+8 at 0; jal x1,-8 at 0x10
    prog = '{32'h00000463, 32'd0, 32'd0, 32'd0, 32'hFF9FF0EF};
    load_program(prog, 1'b0);
    @(negedge clk); #1;
    check("beq_pc", dut.PC, 32'h8);
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("jal_at_pc", dut.PC, 32'h10);
    check("jal_regwrite", {31'd0, dut.RegWrite}, 32'd1);
    @(negedge clk); #1;
    check("jal_pc", dut.PC, 32'h8);
    check("jal_x1", dut.regfile.regs[1], 32'h14);

    // Shift and compare corners on an all-ones value
    prog = '{32'hFFF00093, 32'h0010D113, 32'h4010D193, 32'h00103233, 32'h0000A2B3};
    load_program(prog, 1'b0);
    repeat (5) begin
      @(negedge clk);
      #1;
    end
    check("alu_x1", dut.regfile.regs[1], 32'hFFFFFFFF);
    check("alu_srli", dut.regfile.regs[2], 32'h7FFFFFFF);
    check("alu_srai", dut.regfile.regs[3], 32'hFFFFFFFF);
    check("alu_sltu", dut.regfile.regs[4], 32'd1);
    check("alu_slt", dut.regfile.regs[5], 32'd1);

    // Random programs against the reference model, some with a mid-run reset
    for (int p = 0; p < 4; p++) begin
      prog = {};
      prog.push_back({7'($urandom), 5'($urandom_range(0, 7)), 5'd0, 3'd2, 5'($urandom), 7'h23});
      for (int i = 1; i < 64; i++) prog.push_back(rand_instr());
      load_program(prog, 1'b1);
      run_cycles(150, $sformatf("rnd%0d", p));
      if (p % 2 == 1) begin
        model_peek();
        model_commit();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check($sformatf("midrst%0d_pc", p), dut.PC, 32'h0);
        for (int r = 0; r < 32; r++)
          check($sformatf("midrst%0d_x%0d", p, r), dut.regfile.regs[r], 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        run_cycles(150, $sformatf("rnd%0d_resume", p));
      end
      compare_all($sformatf("rnd%0d_end", p));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
